// File: rtl/bullet_pkg.sv
// Shared codes and limits for the bullet pool: tank orientations, map classes,
// screen bounds and the per-slot state encoding.
package bullet_pkg;

  typedef enum logic [1:0] {
    DirN = 2'd0,
    DirE = 2'd1,
    DirS = 2'd2,
    DirW = 2'd3
  } dir_e;

  localparam logic [2:0] OrientN = 3'b000;
  localparam logic [2:0] OrientE = 3'b010;
  localparam logic [2:0] OrientS = 3'b100;
  localparam logic [2:0] OrientW = 3'b110;

  typedef enum logic [1:0] {
    WorldEmpty = 2'b00,
    WorldGreen = 2'b01,
    WorldWall  = 2'b10,
    WorldRed   = 2'b11
  } world_e;

  localparam logic [1:0]  IconOpTank = 2'b01;
  localparam logic [11:0] MaxCol     = 12'd1023;
  localparam logic [11:0] MaxRow     = 12'd767;

  typedef enum logic {
    StIdle,
    StFlight
  } slot_state_e;

  function automatic logic orient_valid(input logic [2:0] orient);
    return orient inside {OrientN, OrientE, OrientS, OrientW};
  endfunction

  function automatic dir_e orient_to_dir(input logic [2:0] orient);
    return dir_e'(orient[2:1]);
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Scan-side bus between the video pipeline (master) and the bullet pool (slave).
interface bullet_pool_if;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic [1:0]  world_pixel;
  logic [1:0]  icon_op;
  logic        bullet;
  logic [8:0]  bul_addr;
  logic [2:0]  bul_slot;

  modport master (
    output pixel_row, pixel_column, world_pixel, icon_op,
    input  bullet, bul_addr, bul_slot
  );

  modport slave (
    input  pixel_row, pixel_column, world_pixel, icon_op,
    output bullet, bul_addr, bul_slot
  );
endinterface

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLIGHT state, orientation and position, stepping on each
// movement tick and dropping back to IDLE when it would leave the screen.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int unsigned STEP_PX = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spawn_i,
  input  dir_e        spawn_dir_i,
  input  logic [11:0] spawn_row_i,
  input  logic [11:0] spawn_col_i,
  input  logic        tick_i,
  input  logic        retire_i,
  output logic        busy_o,
  output dir_e        dir_o,
  output logic [11:0] row_o,
  output logic [11:0] col_o
);

  localparam logic [12:0] Step = 13'(STEP_PX);

  slot_state_e state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [11:0] row_q, row_d, col_q, col_d;
  logic [12:0] row_w, col_w;
  logic        out_of_range;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    row_w   = {1'b0, row_q};
    col_w   = {1'b0, col_q};
    // 13-bit math: a borrow wraps far above the limit, so one compare covers both edges
    unique case (dir_q)
      DirN: row_w = {1'b0, row_q} - Step;
      DirE: col_w = {1'b0, col_q} + Step;
      DirS: row_w = {1'b0, row_q} + Step;
      DirW: col_w = {1'b0, col_q} - Step;
    endcase
    out_of_range = (dir_q inside {DirN, DirS}) ? (row_w > {1'b0, MaxRow})
                                               : (col_w > {1'b0, MaxCol});
    unique case (state_q)
      StIdle: begin
        if (spawn_i) begin
          state_d = StFlight;
          dir_d   = spawn_dir_i;
          row_d   = spawn_row_i;
          col_d   = spawn_col_i;
        end
      end
      StFlight: begin
        if (retire_i || (tick_i && out_of_range)) begin
          state_d = StIdle;
        end else if (tick_i) begin
          row_d = row_w[11:0];
          col_d = col_w[11:0];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= DirN;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign busy_o = (state_q == StFlight);
  assign dir_o  = dir_q;
  assign row_o  = row_q;
  assign col_o  = col_q;

endmodule

// File: rtl/bullet_pool.sv
// Pool of tank bullets: shot allocation with cooldown, movement ticks, scan-time
// drawing with lowest-slot priority, and collision events against map and opponent.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned STEP_PX        = 10,
  parameter int unsigned TICK_DIV       = 32'h1EFFFF,
  parameter int unsigned COOLDOWN_TICKS = 2,
  parameter int unsigned ICON_PX        = 20,
  parameter int unsigned HOLD_CYCLES    = 32'h2FFFFFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fire,
  input  logic [7:0]           LocX_reg,
  input  logic [7:0]           LocY_reg,
  input  logic [7:0]           BotInfo_reg,
  bullet_pool_if.slave         scan,
  output logic [NUM_SLOTS-1:0] slots_busy,
  output logic                 burst,
  output logic                 burst_base_g,
  output logic                 burst_base_r,
  output logic                 fire_drop
);

  localparam logic [12:0] IconSpan = 13'(ICON_PX - 1);
  localparam logic [8:0]  IconPx   = 9'(ICON_PX);
  localparam logic [8:0]  IconMax  = 9'(ICON_PX - 1);

  logic        fire_q;
  logic [31:0] tick_cnt_q, tick_cnt_d, cool_q, cool_d;
  logic [31:0] hold_g_q, hold_g_d, hold_r_q, hold_r_d;
  logic        bullet_q, bullet_d, burst_q, burst_d, fire_drop_q, fire_drop_d;
  logic [8:0]  bul_addr_q, bul_addr_d;
  logic [2:0]  bul_slot_q, bul_slot_d;

  logic [NUM_SLOTS-1:0] busy, spawn_vec, retire_vec, drawn_vec, hit_vec;
  logic [11:0]          slot_row [NUM_SLOTS];
  logic [11:0]          slot_col [NUM_SLOTS];
  dir_e                 slot_dir [NUM_SLOTS];

  logic        tick, fire_edge, accept, free_any, retire_now, world_hit, tank_hit;
  logic [2:0]  free_idx, sel_idx;
  logic [11:0] y6, x8, spawn_row, spawn_col, sel_row, sel_col;
  dir_e        spawn_dir, sel_dir;
  logic [8:0]  r, c;
  logic        unused_bot;

  assign unused_bot = ^BotInfo_reg[7:3];

  // Spawn position from tank cell coordinates (6-pixel rows, 8-pixel columns)
  always_comb begin
    y6        = 12'(LocY_reg) * 12'd6;
    x8        = {1'b0, LocX_reg, 3'b000};
    spawn_dir = orient_to_dir(BotInfo_reg[2:0]);
    spawn_row = '0;
    spawn_col = '0;
    unique case (spawn_dir)
      DirN: begin spawn_row = y6 - 12'd24; spawn_col = x8 + 12'd6;  end
      DirE: begin spawn_row = y6 + 12'd6;  spawn_col = x8 + 12'd36; end
      DirS: begin spawn_row = y6 + 12'd36; spawn_col = x8 + 12'd6;  end
      DirW: begin spawn_row = y6 + 12'd6;  spawn_col = x8 - 12'd24; end
    endcase
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign spawn_vec[i] = accept && (free_idx == 3'(i));
    assign drawn_vec[i] = (bul_slot_q == 3'(i));
    assign hit_vec[i]   = busy[i]
        && ({1'b0, scan.pixel_row}    >= {1'b0, slot_row[i]})
        && ({1'b0, scan.pixel_row}    <= {1'b0, slot_row[i]} + IconSpan)
        && ({1'b0, scan.pixel_column} >= {1'b0, slot_col[i]})
        && ({1'b0, scan.pixel_column} <= {1'b0, slot_col[i]} + IconSpan);

    bullet_slot #(
      .STEP_PX(STEP_PX)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .spawn_i    (spawn_vec[i]),
      .spawn_dir_i(spawn_dir),
      .spawn_row_i(spawn_row),
      .spawn_col_i(spawn_col),
      .tick_i     (tick),
      .retire_i   (retire_vec[i]),
      .busy_o     (busy[i]),
      .dir_o      (slot_dir[i]),
      .row_o      (slot_row[i]),
      .col_o      (slot_col[i])
    );
  end

  // Draw: lowest-index hit wins, icon address rotated to the slot's heading
  always_comb begin
    sel_idx = '0;
    sel_row = '0;
    sel_col = '0;
    sel_dir = DirN;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_idx = 3'(i);
        sel_row = slot_row[i];
        sel_col = slot_col[i];
        sel_dir = slot_dir[i];
      end
    end
    r = 9'(scan.pixel_row - sel_row);
    c = 9'(scan.pixel_column - sel_col);
    bul_addr_d = '0;
    unique case (sel_dir)
      DirN: bul_addr_d = r * IconPx + c;
      DirE: bul_addr_d = (IconMax - c) * IconPx + r;
      DirS: bul_addr_d = (IconMax - r) * IconPx + (IconMax - c);
      DirW: bul_addr_d = c * IconPx + (IconMax - r);
    endcase
    bullet_d = |hit_vec;
    if (!bullet_d) bul_addr_d = '0;
    bul_slot_d = sel_idx;
  end

  always_comb begin
    tick        = (tick_cnt_q == 32'(TICK_DIV - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 32'd1;
    fire_edge   = fire && !fire_q;
    accept      = fire_edge && (cool_q == '0) && orient_valid(BotInfo_reg[2:0]) && free_any;
    fire_drop_d = fire_edge && !accept;
    cool_d      = cool_q;
    if (accept) begin
      cool_d = 32'(COOLDOWN_TICKS);
    end else if (tick && (cool_q != '0)) begin
      cool_d = cool_q - 32'd1;
    end

    // The drawn slot may already be gone; only a live slot can collide
    world_hit  = (scan.world_pixel != WorldEmpty);
    tank_hit   = (scan.icon_op == IconOpTank);
    retire_now = bullet_q && |(drawn_vec & busy) && (world_hit || tank_hit);
    retire_vec = retire_now ? drawn_vec : '0;
    burst_d    = retire_now && !world_hit && tank_hit;

    hold_g_d = (hold_g_q != '0) ? hold_g_q - 32'd1 : '0;
    hold_r_d = (hold_r_q != '0) ? hold_r_q - 32'd1 : '0;
    if (retire_now && (scan.world_pixel == WorldGreen)) hold_g_d = 32'(HOLD_CYCLES);
    if (retire_now && (scan.world_pixel == WorldRed))   hold_r_d = 32'(HOLD_CYCLES);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fire_q      <= 1'b0;
      tick_cnt_q  <= '0;
      cool_q      <= '0;
      hold_g_q    <= '0;
      hold_r_q    <= '0;
      bullet_q    <= 1'b0;
      bul_addr_q  <= '0;
      bul_slot_q  <= '0;
      burst_q     <= 1'b0;
      fire_drop_q <= 1'b0;
    end else begin
      fire_q      <= fire;
      tick_cnt_q  <= tick_cnt_d;
      cool_q      <= cool_d;
      hold_g_q    <= hold_g_d;
      hold_r_q    <= hold_r_d;
      bullet_q    <= bullet_d;
      bul_addr_q  <= bul_addr_d;
      bul_slot_q  <= bul_slot_d;
      burst_q     <= burst_d;
      fire_drop_q <= fire_drop_d;
    end
  end

  assign scan.bullet   = bullet_q;
  assign scan.bul_addr = bul_addr_q;
  assign scan.bul_slot = bul_slot_q;
  assign slots_busy    = busy;
  assign burst         = burst_q;
  assign burst_base_g  = (hold_g_q != '0);
  assign burst_base_r  = (hold_r_q != '0);
  assign fire_drop     = fire_drop_q;

endmodule
